// File: rtl/adc_cond_pkg.sv
// adc_cond_pkg
//   Shared definitions for the multi-channel ADC conditioner:
//   - conversion-mode encodings for conv_mode bits
//   - saturation limits of a signed sample of a given width
//   - clamp of the requested log2 decimation ratio
package adc_cond_pkg;

   localparam logic CONV_LEGACY = 1'b0;   // {x[MSB], ~x[MSB-1:0]}
   localparam logic CONV_OBIN   = 1'b1;   // {~x[MSB], x[MSB-1:0]}

   // Largest value of a signed number 'bits' wide
   function automatic int sat_max(input int bits);
      return (32'sd1 <<< (bits - 32'sd1)) - 32'sd1;
   endfunction

   // Smallest value of a signed number 'bits' wide
   function automatic int sat_min(input int bits);
      return -(32'sd1 <<< (bits - 32'sd1));
   endfunction

   // Requests above max_dec are treated as max_dec
   function automatic logic [3:0] clamp_dec(input logic [3:0] dec, input int max_dec);
      logic [3:0] res;
      if (int'(dec) > max_dec) begin
         res = 4'(max_dec);
      end else begin
         res = dec;
      end
      return res;
   endfunction

endpackage

// File: rtl/adc_cond_lane.sv
// adc_cond_lane
//   One channel of the conditioner: code conversion (stage 1), offset
//   subtraction with saturation (stage 2) and boxcar accumulate-and-dump
//   (stage 3). Window timing is supplied by the top.
// Ports
//   clk, rst     clock, asynchronous active-low reset
//   adc_i        raw ADC code
//   mode_i       conversion mode (CONV_LEGACY / CONV_OBIN)
//   offset_i     signed offset subtracted after conversion
//   en_i         stage-2 sample is valid (pipeline full)
//   last_i       current sample closes the window
//   clr_i        decimation ratio changed: drop the partial sum
//   dec_i        active log2 decimation ratio (already clamped)
//   ovr_clr_i    clear the sticky overrange flag
//   data_o       conditioned signed sample (registered)
//   ovr_o        sticky saturation flag (registered)
module adc_cond_lane #(
   parameter int BITS         = 14,
   parameter int MAX_LOG2_DEC = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] adc_i,
   input  logic            mode_i,
   input  logic [BITS-1:0] offset_i,
   input  logic            en_i,
   input  logic            last_i,
   input  logic            clr_i,
   input  logic [3:0]      dec_i,
   input  logic            ovr_clr_i,
   output logic [BITS-1:0] data_o,
   output logic            ovr_o
);
   import adc_cond_pkg::*;

   localparam int AW = BITS + MAX_LOG2_DEC;
   localparam logic signed [BITS:0] LIM_HI = (BITS+1)'(sat_max(BITS));
   localparam logic signed [BITS:0] LIM_LO = (BITS+1)'(sat_min(BITS));

   logic        [BITS-1:0] conv_d, conv_q;
   logic signed [BITS:0]   diff_s;
   logic signed [BITS-1:0] d_d, d_q;
   logic                   sat_s;
   logic                   ovr_d, ovr_q;
   logic signed [AW-1:0]   sum_s, shf_s, acc_d, acc_q;
   logic        [BITS-1:0] data_d, data_q;

   // Stage 1: map the raw code to two's complement
   always_comb begin
      if (mode_i == CONV_OBIN) begin
         conv_d = {~adc_i[BITS-1], adc_i[BITS-2:0]};
      end else begin
         conv_d = {adc_i[BITS-1], ~adc_i[BITS-2:0]};
      end
   end

   // Stage 2: subtract one bit wider so the true difference is never lost, then saturate
   always_comb begin
      diff_s = $signed({conv_q[BITS-1], conv_q}) - $signed({offset_i[BITS-1], offset_i});
      if (diff_s > LIM_HI) begin
         d_d   = LIM_HI[BITS-1:0];
         sat_s = 1'b1;
      end else if (diff_s < LIM_LO) begin
         d_d   = LIM_LO[BITS-1:0];
         sat_s = 1'b1;
      end else begin
         d_d   = diff_s[BITS-1:0];
         sat_s = 1'b0;
      end
      // a new saturation beats a coincident clear
      ovr_d = sat_s | (ovr_q & ~ovr_clr_i);
   end

   // Stage 3: accumulate; at window end dump the floor average and restart
   always_comb begin
      sum_s  = acc_q + $signed({{MAX_LOG2_DEC{d_q[BITS-1]}}, d_q});
      shf_s  = sum_s >>> dec_i;
      acc_d  = acc_q;
      data_d = data_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         if (last_i) begin
            acc_d  = '0;
            data_d = shf_s[BITS-1:0];
         end else begin
            acc_d = sum_s;
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Pipeline, accumulator and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conv_q <= '0;
         d_q    <= '0;
         ovr_q  <= 1'b0;
         acc_q  <= '0;
         data_q <= '0;
      end else begin
         conv_q <= conv_d;
         d_q    <= d_d;
         ovr_q  <= ovr_d;
         acc_q  <= acc_d;
         data_q <= data_d;
      end
   end

   assign data_o = data_q;
   assign ovr_o  = ovr_q;

endmodule

// File: rtl/adc_cond_nch.sv
// adc_cond_nch
//   Multi-channel ADC front-end conditioner. Owns the shared window counter,
//   the decimation clamp / change detection and the pipeline-fill tracking;
//   the per-channel datapath lives in adc_cond_lane.
// Ports
//   clk, rst     clock, asynchronous active-low reset
//   adc_i        raw codes, channel k at [k*BITS +: BITS]
//   conv_mode    per-channel conversion mode
//   offset_i     per-channel signed offsets
//   dec_log2_i   requested log2 decimation ratio (clamped to MAX_LOG2_DEC)
//   ovr_clr_i    clears every sticky overrange flag
//   data_o       conditioned samples, channel k at [k*BITS +: BITS]
//   valid_o      one-cycle strobe when data_o is new
//   ovr_o        per-channel sticky saturation flags
module adc_cond_nch #(
   parameter int BITS         = 14,
   parameter int NCH          = 2,
   parameter int MAX_LOG2_DEC = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH*BITS-1:0] adc_i,
   input  logic [NCH-1:0]      conv_mode,
   input  logic [NCH*BITS-1:0] offset_i,
   input  logic [3:0]          dec_log2_i,
   input  logic                ovr_clr_i,
   output logic [NCH*BITS-1:0] data_o,
   output logic                valid_o,
   output logic [NCH-1:0]      ovr_o
);
   import adc_cond_pkg::*;

   logic [3:0]              dec_new_s, dec_q;
   logic                    chg_s;
   logic [1:0]              vld_q;
   logic                    en_s;
   logic [MAX_LOG2_DEC-1:0] last_mask_s, cnt_d, cnt_q;
   logic                    last_s;
   logic                    valid_d, valid_q;

   // Window control: terminal count is 2^dec-1, i.e. the low dec bits set
   always_comb begin
      dec_new_s = clamp_dec(dec_log2_i, MAX_LOG2_DEC);
      chg_s     = (dec_new_s != dec_q);
      en_s      = vld_q[1];
      for (int i = 0; i < MAX_LOG2_DEC; i++) begin
         last_mask_s[i] = (i < int'(dec_q));
      end
      last_s  = (cnt_q == last_mask_s);
      valid_d = en_s & last_s & ~chg_s;
      if (chg_s) begin
         cnt_d = '0;
      end else if (en_s) begin
         cnt_d = last_s ? '0 : cnt_q + MAX_LOG2_DEC'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Control registers: active ratio, fill tracker, counter, strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dec_q   <= 4'd0;
         vld_q   <= 2'b00;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         dec_q   <= dec_new_s;
         vld_q   <= {vld_q[0], 1'b1};
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign valid_o = valid_q;

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      adc_cond_lane #(
         .BITS        (BITS),
         .MAX_LOG2_DEC(MAX_LOG2_DEC)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .adc_i    (adc_i[k*BITS +: BITS]),
         .mode_i   (conv_mode[k]),
         .offset_i (offset_i[k*BITS +: BITS]),
         .en_i     (en_s),
         .last_i   (last_s),
         .clr_i    (chg_s),
         .dec_i    (dec_q),
         .ovr_clr_i(ovr_clr_i),
         .data_o   (data_o[k*BITS +: BITS]),
         .ovr_o    (ovr_o[k])
      );
   end

endmodule
